router_port_sink: RTL and testbench

//  Downstream consumer of one router output port. Drains packets from the port FIFO

---
 rtl/router_port_sink.sv | 124 ++++++++++++
 tb/tb_router_port_sink.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/router_port_sink.sv
// router_port_sink: drains one router port FIFO, strips header/parity, streams payload, reports per-packet status
// Ports: clk/rst (async active-high); vld_out/dout/rd_en port FIFO read side;
//   m_data/m_valid/m_last/m_ready payload byte stream; pkt_done/parity_err/addr_err/trunc_err
//   registered per-packet status; pkt_len header length field; pkt_cnt finished-packet count.
module router_port_sink #(
  parameter logic [1:0] PORT_ID = 2'd0,
  parameter int         TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vld_out,
  input  logic [7:0]  dout,
  output logic        rd_en,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
  output logic        pkt_done,
  output logic        parity_err,
  output logic        addr_err,
  output logic        trunc_err,
  output logic [5:0]  pkt_len,
  output logic [15:0] pkt_cnt
);
  typedef enum logic [2:0] {IDLE, HDR, PLD, PAR, DONE} state_t;
  state_t      r_state;
  logic        r_infl;
  logic [6:0]  r_rem;
  logic [7:0]  r_par;
  logic [7:0]  r_tmo;
  logic [1:0]  r_addr;
  logic [7:0]  r_mem [2];
  logic [1:0]  r_ml;
  logic        r_wp;
  logic        r_rp;
  logic [1:0]  r_occ;
  logic [6:0]  w_need;
  logic        w_busy;
  logic        w_tick;
  logic        w_tmo;
  logic        w_push;
  logic        w_pop;
  // r_rem counts bytes of the packet not yet returned (in-flight byte included); in IDLE only the header is needed
  assign w_need  = (r_state == IDLE) ? 7'd1 : r_rem;
  assign w_busy  = (r_state == HDR) | (r_state == PLD) | (r_state == PAR);
  assign rd_en   = vld_out & (r_state != DONE) & ({6'd0, r_infl} < w_need)
                 & (({1'b0, r_occ} + {2'b0, r_infl}) < 3'd2);
  assign w_tick  = w_busy & ~r_infl & ~vld_out;
  assign w_tmo   = w_tick & (r_tmo == 8'(TIMEOUT - 1));
  assign w_push  = r_infl & (r_state == PLD);
  assign m_valid = (r_occ != 2'd0);
  assign w_pop   = m_valid & m_ready;
  assign m_data  = r_mem[r_rp];
  // on a truncating timeout the sole buffered byte may leave this very cycle, so mark it combinationally too
  assign m_last  = m_valid & (r_ml[r_rp] | (w_tmo & (r_state == PLD) & (r_occ == 2'd1)));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_infl     <= 1'b0;
      r_rem      <= 7'd0;
      r_par      <= 8'd0;
      r_tmo      <= 8'd0;
      r_addr     <= 2'd0;
      r_mem[0]   <= 8'd0;
      r_mem[1]   <= 8'd0;
      r_ml       <= 2'd0;
      r_wp       <= 1'b0;
      r_rp       <= 1'b0;
      r_occ      <= 2'd0;
      pkt_done   <= 1'b0;
      parity_err <= 1'b0;
      addr_err   <= 1'b0;
      trunc_err  <= 1'b0;
      pkt_len    <= 6'd0;
      pkt_cnt    <= 16'd0;
    end else begin
      r_infl   <= rd_en;
      pkt_done <= 1'b0;
      r_tmo    <= (r_infl | ~w_busy) ? 8'd0 : w_tick ? r_tmo + 8'd1 : r_tmo;
      if (w_tmo) begin
        r_state    <= DONE;
        pkt_done   <= 1'b1;
        parity_err <= 1'b0;
        addr_err   <= (r_addr != PORT_ID);
        trunc_err  <= 1'b1;
        pkt_cnt    <= pkt_cnt + 16'd1;
        if (r_state == PLD && r_occ != 2'd0) r_ml[~r_wp] <= 1'b1;
      end else begin
        case (r_state)
          IDLE: if (rd_en) r_state <= HDR;
          HDR: if (r_infl) begin
            pkt_len <= dout[7:2];
            r_addr  <= dout[1:0];
            r_par   <= dout;
            r_rem   <= (dout[7:2] == 6'd0) ? 7'd1 : {1'b0, dout[7:2]} + 7'd1;
            r_state <= (dout[7:2] == 6'd0) ? PAR : PLD;
          end
          PLD: if (r_infl) begin
            r_par <= r_par ^ dout;
            r_rem <= r_rem - 7'd1;
            if (r_rem == 7'd2) r_state <= PAR;
          end
          PAR: if (r_infl) begin
            r_rem      <= 7'd0;
            r_state    <= DONE;
            pkt_done   <= 1'b1;
            parity_err <= (dout != r_par);
            addr_err   <= (r_addr != PORT_ID);
            trunc_err  <= 1'b0;
            pkt_cnt    <= pkt_cnt + 16'd1;
          end
          default: r_state <= IDLE;
        endcase
      end
      if (w_push) begin
        r_mem[r_wp] <= dout;
        r_ml[r_wp]  <= (r_rem == 7'd2);
        r_wp        <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
    end
  end
endmodule

// File: tb/tb_router_port_sink.sv
// tb_router_port_sink: randomized scoreboard bench for router_port_sink
module tb_router_port_sink;
  localparam int TMO = 8;
  logic        clk = 1'b0, rst = 1'b1, vld_out = 1'b0, m_ready = 1'b0;
  logic [7:0]  dout = 8'd0;
  logic        rd_en, m_valid, m_last, pkt_done, parity_err, addr_err, trunc_err;
  logic [7:0]  m_data;
  logic [5:0]  pkt_len;
  logic [15:0] pkt_cnt;
  logic [7:0]  src [$];
  logic [8:0]  exp_b [$];
  logic [8:0]  exp_s [$];
  int          vecs = 0, errs = 0, cnt_model = 0, rdy_mode = 0, hold_run = 0;
  logic        rd_q;
  always #5 clk = ~clk;
  router_port_sink #(.PORT_ID(2'd0), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .vld_out(vld_out), .dout(dout), .rd_en(rd_en),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .pkt_done(pkt_done), .parity_err(parity_err), .addr_err(addr_err),
    .trunc_err(trunc_err), .pkt_len(pkt_len), .pkt_cnt(pkt_cnt)
  );
  always @(posedge clk or posedge rst)
    if (rst) rd_q <= 1'b0;
    else rd_q <= rd_en;
  // port FIFO model: a read sampled at an edge returns its byte just after that edge
  always @(posedge clk) begin
    logic hold;
    #1;
    if (rd_q) begin
      vecs++;
      if (src.size() == 0) begin
        errs++;
        $display("FAIL rd_empty: rd_en=1 required 0 (FIFO empty)");
      end else dout = src.pop_front();
    end
    hold = (hold_run < 3) && ($urandom_range(3) == 0);
    hold_run = hold ? hold_run + 1 : 0;
    vld_out = (src.size() > 0) && !hold;
    m_ready = (rdy_mode == 2) ? 1'b1 : (rdy_mode == 1) ? ($urandom_range(2) != 0) : 1'b0;
  end
  always @(negedge clk) if (!rst) begin
    logic [8:0] e;
    if (m_valid && m_ready) begin
      vecs++;
      if (exp_b.size() == 0) begin
        errs++;
        $display("FAIL beat: got last=%0b data=%h, required none", m_last, m_data);
      end else begin
        e = exp_b.pop_front();
        if ({m_last, m_data} != e) begin
          errs++;
          $display("FAIL beat: got last=%0b data=%h, required last=%0b data=%h", m_last, m_data, e[8], e[7:0]);
        end
      end
    end
    if (pkt_done) begin
      vecs += 2;
      cnt_model++;
      if (exp_s.size() == 0) begin
        errs++;
        $display("FAIL status: unexpected pkt_done");
      end else begin
        e = exp_s.pop_front();
        if ({parity_err, addr_err, trunc_err, pkt_len} != e) begin
          errs++;
          $display("FAIL status: got par=%0b addr=%0b trunc=%0b len=%0d, required par=%0b addr=%0b trunc=%0b len=%0d",
                   parity_err, addr_err, trunc_err, pkt_len, e[8], e[7], e[6], e[5:0]);
        end
      end
      if (pkt_cnt != 16'(cnt_model)) begin
        errs++;
        $display("FAIL pkt_cnt: got %0d required %0d", pkt_cnt, cnt_model);
      end
    end
  end
  // keep < 0: whole packet; otherwise only header and the first keep payload bytes reach the FIFO
  task automatic send(input logic [5:0] len, input logic [1:0] addr, input bit bad, input int keep, input bit fixed);
    logic [7:0] hdr, p, b;
    hdr = {len, addr};
    p = hdr;
    src.push_back(hdr);
    for (int i = 0; i < int'(len); i++) begin
      b = fixed ? 8'((i + 1) * 17) : 8'($urandom);
      p ^= b;
      if (keep < 0 || i < keep) begin
        src.push_back(b);
        exp_b.push_back({(keep < 0) ? (i == int'(len) - 1) : (i == keep - 1), b});
      end
    end
    if (keep < 0) begin
      src.push_back(bad ? p ^ 8'h01 : p);
      exp_s.push_back({bad, addr != 2'd0, 1'b0, len});
    end else exp_s.push_back({1'b0, addr != 2'd0, 1'b1, len});
  endtask
  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((src.size() != 0 || exp_b.size() != 0 || exp_s.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    vecs++;
    if (n >= 3000) begin
      errs++;
      $display("FAIL %s: drain timeout, src=%0d beats=%0d status=%0d required 0", tag, src.size(), exp_b.size(), exp_s.size());
      src.delete();
      exp_b.delete();
      exp_s.delete();
    end
  endtask
  task automatic check_zero(input string tag);
    vecs++;
    if ({m_valid, m_last, m_data, pkt_done, parity_err, addr_err, trunc_err, pkt_len, pkt_cnt} != 0) begin
      errs++;
      $display("FAIL %s: outputs v=%0b l=%0b d=%h done=%0b pe=%0b ae=%0b te=%0b len=%0d cnt=%0d required all 0",
               tag, m_valid, m_last, m_data, pkt_done, parity_err, addr_err, trunc_err, pkt_len, pkt_cnt);
    end
  endtask
  initial begin
    logic [5:0] len;
    logic [1:0] addr;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    rdy_mode = 2;
    send(6'd3, 2'd0, 1'b0, -1, 1'b1);
    send(6'd3, 2'd0, 1'b1, -1, 1'b1);
    send(6'd3, 2'd1, 1'b0, -1, 1'b1);
    send(6'd0, 2'd0, 1'b0, -1, 1'b0);
    send(6'd2, 2'd0, 1'b0, -1, 1'b0);
    wait_idle("directed");
    rdy_mode = 0;
    send(6'd3, 2'd0, 1'b0, -1, 1'b0);
    repeat (12) @(negedge clk);
    vecs++;
    if (src.size() != 2 || !m_valid) begin
      errs++;
      $display("FAIL backpressure: fifo left=%0d m_valid=%0b required 2 and 1", src.size(), m_valid);
    end
    rdy_mode = 1;
    wait_idle("backpressure");
    for (int t = 0; t < 50; t++) begin
      len = ($urandom_range(7) == 0) ? 6'($urandom_range(63)) : 6'($urandom_range(6));
      addr = ($urandom_range(3) == 0) ? 2'($urandom_range(3)) : 2'd0;
      if (t == 0 || (len != 0 && $urandom_range(7) == 0)) begin
        if (t == 0) len = 6'd3;
        wait_idle("pre_trunc");
        rdy_mode = 0;
        send(len, addr, 1'b0, (t == 0) ? 2 : $urandom_range((len > 2) ? 2 : int'(len) - 1), 1'b0);
        for (int n = 0; n < 200 && exp_s.size() != 0; n++) @(negedge clk);
        rdy_mode = 1;
        wait_idle("trunc");
      end else begin
        @(negedge clk);
        send(len, addr, $urandom_range(4) == 0, -1, 1'b0);
        if ($urandom_range(3) == 0) repeat ($urandom_range(6)) @(negedge clk);
      end
    end
    wait_idle("random");
    rdy_mode = 0;
    send(6'd20, 2'd0, 1'b0, -1, 1'b0);
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_zero("mid_reset");
    src.delete();
    exp_b.delete();
    exp_s.delete();
    cnt_model = 0;
    @(negedge clk);
    rst = 1'b0;
    rdy_mode = 2;
    send(6'd3, 2'd0, 1'b0, -1, 1'b1);
    wait_idle("post_reset");
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
